latch_bank_readout: RTL and testbench

- Reader side for a bank of CC_DLT latch outputs in a verification top.
- On request, samples the latch-output vector through a 2-flop synchroniser and takes a snapshot.
- Shifts the snapshot off-chip as a framed, CRC-protected SPI-mode-0 stream, so the bench can read the latch states through a few pins.

---
 rtl/latch_readout_pkg.sv | 22 ++
 rtl/readout_bit_timer.sv | 43 ++++
 rtl/latch_bank_readout.sv | 149 ++++++++++++++
 tb/tb_latch_bank_readout.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/latch_readout_pkg.sv
// Shared types and CRC helper for the latch-bank readout block.
package latch_readout_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_CRC,
    ST_FIN
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  // One serial step of CRC-8 (x^8+x^2+x+1), MSB-first register.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/readout_bit_timer.sv
// Divides clk into serial bit periods: sclk low for DIV cycles, then high for DIV cycles.
module readout_bit_timer #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sclk,
  output logic bit_start,
  output logic bit_end
);

  localparam int CW = $clog2(2 * DIV);
  localparam logic [CW-1:0] LAST = CW'(2 * DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d;

  // sclk is registered from the next count so it lines up with cnt_q.
  always_comb begin
    cnt_d = '0;
    if (run) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
    sclk_d = run && (cnt_d >= HALF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk      = sclk_q;
  assign bit_start = run && (cnt_q == '0);
  assign bit_end   = run && (cnt_q == LAST);

endmodule

// File: rtl/latch_bank_readout.sv
// Synchronises a latch-output bank, snapshots it on request and shifts it out as
// a framed SPI-mode-0 stream: header byte, data LSB first, CRC-8 MSB first.
module latch_bank_readout #(
  parameter int         WIDTH = 44,
  parameter int         DIV   = 4,
  parameter logic [7:0] HDR   = 8'hA5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             scs_n,
  output logic             sclk,
  output logic             sdo
);

  import latch_readout_pkg::*;

  localparam int FL = WIDTH + 16;
  localparam int BW = $clog2(FL);
  localparam logic [BW-1:0] HDR_LAST  = BW'(7);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH + 7);
  localparam logic [BW-1:0] CRC_LAST  = BW'(FL - 1);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [7:0]       crc_q, crc_d;
  logic [7:0]       out_q, out_d;
  logic [BW-1:0]    bit_q, bit_d;
  state_t           state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             scs_n_q, scs_n_d, sdo_q, sdo_d;
  logic             bit_end, bit_start_unused;

  readout_bit_timer #(.DIV(DIV)) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (busy_q),
    .sclk      (sclk),
    .bit_start (bit_start_unused),
    .bit_end   (bit_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= q;
      sync2_q <= sync1_q;
    end
  end

  // Each new bit is loaded on the bit_end of the previous one, i.e. at the
  // start of its own period. The snapshot shifts right as data bits go out.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    crc_d   = crc_q;
    out_d   = out_q;
    bit_d   = bit_q;
    busy_d  = busy_q;
    scs_n_d = scs_n_q;
    sdo_d   = sdo_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR;
          snap_d  = sync2_q;
          crc_d   = CRC8_INIT;
          bit_d   = '0;
          busy_d  = 1'b1;
          scs_n_d = 1'b0;
          sdo_d   = HDR[7];
          out_d   = {HDR[6:0], 1'b0};
        end
      end
      ST_HDR, ST_DATA: begin
        if (bit_end) begin
          bit_d = bit_q + BW'(1);
          if (state_q == ST_DATA && bit_q == DATA_LAST) begin
            state_d = ST_CRC;
            sdo_d   = crc_q[7];
            out_d   = {crc_q[6:0], 1'b0};
          end else if (state_q == ST_DATA || bit_q == HDR_LAST) begin
            state_d = ST_DATA;
            sdo_d   = snap_q[0];
            snap_d  = snap_q >> 1;
            crc_d   = crc8_step(crc_q, snap_q[0]);
          end else begin
            sdo_d = out_q[7];
            out_d = {out_q[6:0], 1'b0};
          end
        end
      end
      ST_CRC: begin
        if (bit_end) begin
          if (bit_q == CRC_LAST) begin
            state_d = ST_FIN;
            bit_d   = '0;
            busy_d  = 1'b0;
            scs_n_d = 1'b1;
            sdo_d   = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + BW'(1);
            sdo_d = out_q[7];
            out_d = {out_q[6:0], 1'b0};
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      crc_q   <= CRC8_INIT;
      out_q   <= '0;
      bit_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scs_n_q <= 1'b1;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      crc_q   <= crc_d;
      out_q   <= out_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scs_n_q <= scs_n_d;
      sdo_q   <= sdo_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign scs_n = scs_n_q;
  assign sdo   = sdo_q;

endmodule

// File: tb/tb_latch_bank_readout.sv
// Scoreboard bench for latch_bank_readout: expected frames come from a
// polynomial-division CRC model; a monitor captures the SPI stream.
module tb_latch_bank_readout;

  localparam int         WIDTH     = 44;
  localparam int         DIV       = 4;
  localparam logic [7:0] HDR       = 8'hA5;
  localparam int         FL        = WIDTH + 16;
  localparam int         FRAME_CYC = FL * 2 * DIV;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] q     = '0;
  logic             busy, done, scs_n, sclk, sdo;

  int tests = 0;
  int failures = 0;
  int pushed = 0;
  int done_seen = 0;
  logic [FL-1:0] exp_q[$];

  latch_bank_readout #(.WIDTH(WIDTH), .DIV(DIV), .HDR(HDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q),
    .start (start),
    .busy  (busy),
    .done  (done),
    .scs_n (scs_n),
    .sclk  (sclk),
    .sdo   (sdo)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // CRC as remainder of message(x) * x^8 divided by x^8+x^2+x+1, first-sent bit highest.
  function automatic logic [7:0] ref_crc(input logic [WIDTH-1:0] d);
    logic [WIDTH+7:0] r = '0;
    for (int i = 0; i < WIDTH; i++) r[WIDTH+7-i] = d[i];
    for (int k = WIDTH + 7; k >= 8; k--)
      if (r[k]) r[k -: 9] = r[k -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  // Bit i of the result is the i-th bit on the wire.
  function automatic logic [FL-1:0] ref_frame(input logic [WIDTH-1:0] d);
    logic [FL-1:0] f;
    logic [7:0]    c = ref_crc(d);
    logic [7:0]    h = HDR;
    for (int i = 0; i < 8; i++) begin
      f[i]        = h[7-i];
      f[FL-8+i]   = c[7-i];
    end
    for (int i = 0; i < WIDTH; i++) f[8+i] = d[i];
    return f;
  endfunction

  function automatic logic [WIDTH-1:0] rand_q();
    logic [63:0] r = {$urandom, $urandom};
    return r[WIDTH-1:0];
  endfunction

  // Monitor: captures bits on sclk rising, checks phase lengths and sdo stability,
  // and scores a complete frame whenever done pulses.
  logic [FL-1:0] cap;
  int   ncap, busy_cnt, run_len, bad_runs, unstable;
  logic p_scs_low, p_sclk, p_sdo, p_done;

  always @(negedge clk) begin
    if (!rst_n) begin
      cap = '0; ncap = 0; busy_cnt = 0; run_len = 0; bad_runs = 0; unstable = 0;
      p_scs_low = 1'b0; p_sclk = 1'b0; p_sdo = 1'b0; p_done = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (!scs_n) begin
        if (p_scs_low && sclk == p_sclk) run_len++;
        else begin
          if (p_scs_low && run_len != DIV) bad_runs++;
          run_len = 1;
        end
        if (sclk && !p_sclk) begin
          if (ncap < FL) cap[ncap] = sdo;
          ncap++;
        end
        if (p_scs_low && sdo !== p_sdo && !(p_sclk && !sclk)) unstable++;
      end else if (p_scs_low) begin
        if (run_len != DIV) bad_runs++;
      end
      if (done) begin
        done_seen++;
        checkOutput("done pulse width", p_done, 1'b0);
        checkOutput("done count", done_seen, pushed);
        if (exp_q.size() > 0) begin
          checkOutput("frame bits", cap, exp_q.pop_front());
          checkOutput("bit count", ncap, FL);
        end
        checkOutput("busy cycles", busy_cnt, FRAME_CYC);
        checkOutput("sclk phase length", bad_runs, 0);
        checkOutput("sdo stability", unstable, 0);
        checkOutput("scs_n at done", scs_n, 1'b1);
        checkOutput("sclk at done", sclk, 1'b0);
        checkOutput("sdo at done", sdo, 1'b0);
        cap = '0; ncap = 0; busy_cnt = 0; bad_runs = 0; unstable = 0;
      end
      p_scs_low = !scs_n; p_sclk = sclk; p_sdo = sdo; p_done = done;
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] qv, input int settle, input bit expect_done);
    q = qv;
    repeat (settle) @(negedge clk);
    checkOutput("idle scs_n", scs_n, 1'b1);
    checkOutput("idle busy", busy, 1'b0);
    if (expect_done) begin
      exp_q.push_back(ref_frame(qv));
      pushed++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("scs_n fall", scs_n, 1'b0);
    checkOutput("busy rise", busy, 1'b1);
    checkOutput("first header bit", sdo, HDR[7]);
  endtask

  // Returns at the negedge inside the done cycle.
  task automatic waitDone(input bit toggle, input bit restart);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < FRAME_CYC + 20) begin
      @(negedge clk);
      n++;
      if (done) seen = 1'b1;
      else begin
        if (toggle) q = rand_q();
        start = (restart && (n % 97 == 5)) ? 1'b1 : 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("done seen", seen, 1'b1);
  endtask

  initial begin
    int   n, rises;
    logic ps;
    logic [WIDTH-1:0] qa, qb;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", done, 1'b0);
    checkOutput("reset scs_n", scs_n, 1'b1);
    checkOutput("reset sclk", sclk, 1'b0);
    checkOutput("reset sdo", sdo, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus('0, 3, 1'b1);
    waitDone(1'b0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(rand_q(), 3, 1'b1);
      waitDone(i[0], i[1]);
    end

    applyStimulus('1, 3, 1'b1);
    waitDone(1'b1, 1'b1);

    // start during the done cycle must be dropped
    applyStimulus(rand_q(), 3, 1'b1);
    waitDone(1'b0, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("fin start ignored scs_n", scs_n, 1'b1);
    checkOutput("fin start ignored busy", busy, 1'b0);

    // back-to-back frames with a new q value
    qa = rand_q();
    qb = rand_q();
    applyStimulus(qa, 3, 1'b1);
    q = qb;
    waitDone(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("gap done low", done, 1'b0);
    applyStimulus(qb, 0, 1'b1);
    waitDone(1'b0, 1'b0);

    // abort mid-frame with reset
    applyStimulus(rand_q(), 3, 1'b0);
    n = 0; rises = 0; ps = sclk;
    while (rises < 20 && n < FRAME_CYC) begin
      @(negedge clk);
      n++;
      if (sclk && !ps) rises++;
      ps = sclk;
    end
    checkOutput("reached bit 20", rises, 20);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort scs_n", scs_n, 1'b1);
    checkOutput("abort sclk", sclk, 1'b0);
    checkOutput("abort sdo", sdo, 1'b0);
    checkOutput("abort busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("no resume after reset", scs_n, 1'b1);
    applyStimulus(rand_q(), 3, 1'b1);
    waitDone(1'b1, 1'b0);

    repeat (5) @(negedge clk);
    checkOutput("pending frames", exp_q.size(), 0);
    checkOutput("done total", done_seen, pushed);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
